// File: rtl/decoder3x8_pulse_sequencer_pkg.sv
// Shared definitions for the 3-to-8 pulse sequencer.
//   CODE_W / OUT_W : width of the binary code and of the one-hot output
//   state_e        : sequencer states (IDLE, HOLD, GAP)
//   onehot8()      : binary code -> one-hot output word
package decoder3x8_pulse_sequencer_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [OUT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder3x8_pulse_sequencer_if.sv
// Handshake / output bundle of the pulse sequencer.
//   enable, valid, code : upstream -> sequencer
//   ready, q, busy, done: sequencer -> upstream / downstream strobes
// master = upstream controller, slave = sequencer.
interface decoder3x8_pulse_sequencer_if;
  import decoder3x8_pulse_sequencer_pkg::*;

  logic              enable;
  logic              valid;
  logic [CODE_W-1:0] code;
  logic              ready;
  logic [OUT_W-1:0]  q;
  logic              busy;
  logic              done;

  modport master (
    output enable, valid, code,
    input  ready, q, busy, done
  );

  modport slave (
    input  enable, valid, code,
    output ready, q, busy, done
  );

endinterface

// File: rtl/decoder3x8_pulse_sequencer_code_queue_fifo.sv
// Synchronous code FIFO placed in front of the sequencer.
// Only compiled when DECODER_QUEUE_EN is defined.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   flush_i          : empties the FIFO on the next edge
//   push_i / data_i  : write a code (ignored when full unless popping)
//   pop_i  / data_o  : read the head code (data_o valid when !empty_o)
//   full_o, empty_o  : occupancy flags
// DEPTH must be a power of two (pointers wrap naturally).
`ifdef DECODER_QUEUE_EN
module decoder3x8_pulse_sequencer_code_queue_fifo
  import decoder3x8_pulse_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = CODE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only alongside a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`endif

// File: rtl/decoder3x8_pulse_sequencer.sv
// Registered 3-to-8 decoder that turns each accepted code into a one-hot
// pulse on q lasting HOLD_CYCLES cycles, followed by a done strobe and
// GAP_CYCLES further idle cycles before the next code is taken.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of decoder3x8_pulse_sequencer_if
//                (enable, valid, code in; ready, q, busy, done out)
// Build option:
//   DECODER_QUEUE_EN : adds a QUEUE_DEPTH-entry code FIFO so codes can be
//                      accepted while a pulse is in progress.
module decoder3x8_pulse_sequencer
  import decoder3x8_pulse_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input logic                         clk,
  input logic                         reset,
  decoder3x8_pulse_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of two and at least 2");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  q_q, q_d;
  logic              done_q, done_d;

  logic              start;
  logic [CODE_W-1:0] start_code;
  logic              queued;

`ifdef DECODER_QUEUE_EN
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CODE_W-1:0] fifo_head;

  // Every accepted code goes through the FIFO; the sequencer launches a
  // pulse from the head whenever it is idle.
  assign fifo_pop   = bus.enable && (state_q == IDLE) && !fifo_empty;
  assign bus.ready  = !reset && bus.enable && (!fifo_full || fifo_pop);
  assign fifo_push  = bus.valid && bus.ready;
  assign start      = fifo_pop;
  assign start_code = fifo_head;
  assign queued     = !fifo_empty;

  decoder3x8_pulse_sequencer_code_queue_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (CODE_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (!bus.enable),
    .push_i  (fifo_push),
    .data_i  (bus.code),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
`else
  assign bus.ready  = !reset && bus.enable && (state_q == IDLE);
  assign start      = bus.valid && bus.ready;
  assign start_code = bus.code;
  assign queued     = 1'b0;
`endif

  // cnt_q counts down the remaining HOLD cycles, then the remaining GAP
  // cycles. GAP is entered on the done cycle with GAP_CYCLES loaded, so it
  // lasts GAP_CYCLES+1 cycles (done cycle plus the forced gap).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      q_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          q_d = '0;
          if (start) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            q_d     = onehot8(start_code);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            q_d    = '0;
            done_d = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              cnt_d   = CNT_W'(GAP_CYCLES);
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          q_d = '0;
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          q_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != IDLE) || queued;

  a_q_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(q_q));
  a_idle_zero : assert property (@(posedge clk) disable iff (reset) (state_q == IDLE) |-> (q_q == '0));

endmodule

// File: tb/tb_decoder3x8_pulse_sequencer.sv
// Bench for decoder3x8_pulse_sequencer: two instances (HOLD=4/GAP=1 and
// HOLD=1/GAP=0) share one stimulus stream and are checked every cycle
// against a pulse-timeline model, plus literal expectations in the
// directed phases.
module tb_decoder3x8_pulse_sequencer;

  localparam int HC0 = 4;
  localparam int GC0 = 1;
  localparam int HC1 = 1;
  localparam int GC1 = 0;
  localparam int QD  = 2;

  logic       clk = 1'b0;
  logic       rst, en, vld;
  logic [2:0] cd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;

  // Model: last launched pulse (start cycle, code) and first cycle the
  // sequencer is free again; plus the code queue for the FIFO build.
  bit         m_act  [2];
  int         m_s    [2];
  logic [2:0] m_code [2];
  int         m_idle [2];
  logic [2:0] mq     [2][QD];
  int         m_n    [2];

  always #5 clk = ~clk;

  decoder3x8_pulse_sequencer_if bus0 ();
  decoder3x8_pulse_sequencer_if bus1 ();

  assign bus0.enable = en;
  assign bus0.valid  = vld;
  assign bus0.code   = cd;
  assign bus1.enable = en;
  assign bus1.valid  = vld;
  assign bus1.code   = cd;

  decoder3x8_pulse_sequencer #(
    .HOLD_CYCLES (HC0),
    .GAP_CYCLES  (GC0),
    .QUEUE_DEPTH (QD)
  ) dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0)
  );

  decoder3x8_pulse_sequencer #(
    .HOLD_CYCLES (HC1),
    .GAP_CYCLES  (GC1),
    .QUEUE_DEPTH (QD)
  ) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  function automatic int hold_of(input int k);
    return (k == 0) ? HC0 : HC1;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? GC0 : GC1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Pulse launched in cycle c: q high in c+1..c+H, done in c+H+1, free
  // again at c+H+1 (no gap) or c+H+1+G+1 (done cycle plus G gap cycles).
  task automatic launch(input int k, input logic [2:0] c);
    int g;
    g         = (gap_of(k) > 0) ? gap_of(k) + 1 : 0;
    m_act[k]  = 1'b1;
    m_s[k]    = cyc;
    m_code[k] = c;
    m_idle[k] = cyc + hold_of(k) + 1 + g;
  endtask

  // Model update: consumes the inputs of the cycle ending at this edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_s[k] = 0; m_code[k] = '0; m_idle[k] = 0; m_n[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst || !en) begin
          m_act[k]  = 1'b0;
          m_idle[k] = cyc + 1;
          m_n[k]    = 0;
        end else begin
`ifdef DECODER_QUEUE_EN
          bit         pop;
          bit         acc;
          logic [2:0] head;
          pop = (cyc >= m_idle[k]) && (m_n[k] > 0);
          acc = vld && ((m_n[k] < QD) || pop);
          if (pop) begin
            head = mq[k][0];
            for (int i = 0; i < QD - 1; i++) mq[k][i] = mq[k][i+1];
            m_n[k]--;
            launch(k, head);
          end
          if (acc) begin
            mq[k][m_n[k]] = cd;
            m_n[k]++;
          end
`else
          if (vld && (cyc >= m_idle[k])) launch(k, cd);
`endif
        end
      end
      if (rst) started = 1'b1;
      cyc++;
    end
  end

  // Compare process: every output of both instances, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          logic [7:0] aq, eq;
          logic       ar, ab, ad, er, eb, ed;
          bit         pop;
          aq = (k == 0) ? bus0.q     : bus1.q;
          ar = (k == 0) ? bus0.ready : bus1.ready;
          ab = (k == 0) ? bus0.busy  : bus1.busy;
          ad = (k == 0) ? bus0.done  : bus1.done;
          eq = 8'h00;
          if (m_act[k] && cyc > m_s[k] && cyc <= m_s[k] + hold_of(k)) eq = 8'h01 << m_code[k];
          ed = m_act[k] && (cyc == m_s[k] + hold_of(k) + 1);
          eb = (cyc < m_idle[k]) || (m_n[k] > 0);
`ifdef DECODER_QUEUE_EN
          pop = (cyc >= m_idle[k]) && (m_n[k] > 0);
          er  = !rst && en && ((m_n[k] < QD) || pop);
`else
          pop = 1'b0;
          er  = !rst && en && (cyc >= m_idle[k]) && !pop;
`endif
          chk($sformatf("cfg%0d q @%0d", k, cyc), aq, eq);
          chk($sformatf("cfg%0d ready @%0d", k, cyc), ar, er);
          chk($sformatf("cfg%0d busy @%0d", k, cyc), ab, eb);
          chk($sformatf("cfg%0d done @%0d", k, cyc), ad, ed);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit 500000 reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus; returns at the following negedge.
  task automatic drive(input logic r, input logic e, input logic v, input logic [2:0] c);
    @(posedge clk);
    #1;
    rst = r; en = e; vld = v; cd = c;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] e;
    one = 8'h01;
    rst = 1'b1; en = 1'b0; vld = 1'b0; cd = '0;

    drive(1, 1, 0, 0);
    chk("reset ready", bus0.ready, 1'b0);
    drive(0, 1, 0, 0);
    chk("post-reset q", bus0.q, 8'h00);
    chk("post-reset busy", bus0.busy, 1'b0);
    chk("post-reset done", bus0.done, 1'b0);
    chk("post-reset ready", bus0.ready, 1'b1);

`ifndef DECODER_QUEUE_EN
    // Sweep every code: 4 hold cycles, done, ready low for 6 cycles.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 3'(i));
      chk($sformatf("sweep%0d accept ready", i), bus0.ready, 1'b1);
      for (int j = 1; j <= 7; j++) begin
        drive(0, 1, 0, 0);
        e = (j >= 1 && j <= 4) ? (one << i) : 8'h00;
        chk($sformatf("sweep%0d q +%0d", i, j), bus0.q, e);
        chk($sformatf("sweep%0d done +%0d", i, j), bus0.done, (j == 5));
        chk($sformatf("sweep%0d ready +%0d", i, j), bus0.ready, (j == 7));
      end
    end

    // valid held: 3 then 5; 5 is taken only after the gap.
    drive(0, 1, 1, 3);
    for (int j = 1; j <= 11; j++) begin
      drive(0, 1, 1, 5);
      e = (j <= 4) ? 8'h08 : ((j >= 8) ? 8'h20 : 8'h00);
      chk($sformatf("held q +%0d", j), bus0.q, e);
      if (j == 7) chk("held second accept", bus0.ready, 1'b1);
    end
    repeat (5) drive(0, 1, 0, 0);

    // enable drops on HOLD cycle 2 of code 6.
    drive(0, 1, 1, 6);
    drive(0, 1, 0, 0);
    chk("abort hold1 q", bus0.q, 8'h40);
    drive(0, 0, 1, 0);
    chk("abort hold2 q", bus0.q, 8'h40);
    chk("abort ready low", bus0.ready, 1'b0);
    drive(0, 0, 1, 2);
    chk("abort q cleared", bus0.q, 8'h00);
    chk("abort no done", bus0.done, 1'b0);
    chk("abort busy", bus0.busy, 1'b0);
    drive(0, 0, 1, 3);
    chk("abort done stays low", bus0.done, 1'b0);
    chk("abort ready still low", bus0.ready, 1'b0);
    drive(0, 1, 1, 1);
    chk("resume ready", bus0.ready, 1'b1);
    drive(0, 1, 0, 0);
    chk("resume q", bus0.q, 8'h02);
    repeat (8) drive(0, 1, 0, 0);

    // HOLD=1, GAP=0 instance: codes 2 and 4 back to back.
    drive(0, 1, 1, 2);
    chk("g0 accept2 ready", bus1.ready, 1'b1);
    drive(0, 1, 1, 4);
    chk("g0 q 2", bus1.q, 8'h04);
    chk("g0 ready in hold", bus1.ready, 1'b0);
    drive(0, 1, 1, 4);
    chk("g0 gap q", bus1.q, 8'h00);
    chk("g0 done 1", bus1.done, 1'b1);
    chk("g0 ready on done", bus1.ready, 1'b1);
    drive(0, 1, 0, 0);
    chk("g0 q 4", bus1.q, 8'h10);
    drive(0, 1, 0, 0);
    chk("g0 end q", bus1.q, 8'h00);
    chk("g0 done 2", bus1.done, 1'b1);
    repeat (8) drive(0, 1, 0, 0);
`else
    // Queue: code 2 starts a pulse, then 7,0,1 pushed during its hold.
    begin
      logic [7:0] seen [4];
      logic [7:0] prevq;
      int         ns;
      int         nonbusy;
      bit         one_acc;
      ns = 0; nonbusy = 0; one_acc = 1'b0; prevq = 8'h00;
      for (int i = 0; i < 4; i++) seen[i] = 8'h00;
      drive(0, 1, 1, 2);
      drive(0, 1, 0, 0);
      chk("queue busy after push", bus0.busy, 1'b1);
      for (int t = 0; t < 40; t++) begin
        if (t == 0)        drive(0, 1, 1, 7);
        else if (t == 1)   drive(0, 1, 1, 0);
        else if (!one_acc) drive(0, 1, 1, 1);
        else               drive(0, 1, 0, 0);
        if (t == 2) chk("queue full ready", bus0.ready, 1'b0);
        if (t >= 2 && !one_acc && bus0.ready) one_acc = 1'b1;
        if (bus0.q != 8'h00 && prevq == 8'h00 && ns < 4) begin
          seen[ns] = bus0.q;
          ns++;
        end
        if (ns < 4 && !bus0.busy) nonbusy++;
        prevq = bus0.q;
      end
      chk("queue pulse count", 32'(ns), 32'd4);
      chk("queue order 0", seen[0], 8'h04);
      chk("queue order 1", seen[1], 8'h80);
      chk("queue order 2", seen[2], 8'h01);
      chk("queue order 3", seen[3], 8'h02);
      chk("queue stalled code accepted", one_acc, 1'b1);
      chk("queue busy gaps", 32'(nonbusy), 32'd0);
      repeat (10) drive(0, 1, 0, 0);
    end
`endif

    // Random traffic with occasional enable drops and resets.
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 19) != 0),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    repeat (12) drive(0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
